// File: rtl/sw_traceback_if.sv
// Alignment-op stream from the traceback engine to the host result FIFO.
interface sw_traceback_if;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic       op_last;

  modport master (output op_valid, output op_code, output op_last, input op_ready);
  modport slave  (input op_valid, input op_code, input op_last, output op_ready);
endinterface

// File: rtl/sw_traceback.sv
// Smith-Waterman traceback: stores the direction matrix column by column,
// tracks the best local-alignment cell, then walks back from it and streams
// the alignment ops (end->start order) on a valid/ready interface.
module sw_traceback #(
  parameter int N_PE     = 16,
  parameter int MAX_COLS = 64,
  parameter int SCORE_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_en_i,
  input  logic                        col_valid_i,
  input  logic [2*N_PE-1:0]           col_dir_i,
  input  logic [N_PE*SCORE_W-1:0]     col_score_i,
  input  logic                        window_end_i,
  sw_traceback_if.master              op_if,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [SCORE_W-1:0]          max_score_o,
  output logic [$clog2(N_PE)-1:0]     end_row_o,
  output logic [$clog2(MAX_COLS)-1:0] end_col_o,
  output logic [$clog2(N_PE)-1:0]     start_row_o,
  output logic [$clog2(MAX_COLS)-1:0] start_col_o,
  output logic                        overflow_o
);

  localparam int RW = $clog2(N_PE);
  localparam int CW = $clog2(MAX_COLS);
  localparam int NW = CW + 1;  // column count must be able to hold MAX_COLS itself

  localparam logic [1:0] DIR_ZERO = 2'd0;
  localparam logic [1:0] DIR_DIAG = 2'd1;
  localparam logic [1:0] DIR_UP   = 2'd2;
  localparam logic [1:0] DIR_LEFT = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SEEK, S_WALK, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [NW-1:0]             col_cnt_q;
  logic signed [SCORE_W-1:0] max_score_q;
  logic [RW-1:0]             end_row_q, start_row_q, cur_row_q;
  logic [CW-1:0]             end_col_q, start_col_q, cur_col_q;
  logic                      overflow_q;
  logic [1:0]                dir_q [MAX_COLS][N_PE];

  logic                      capturing, col_full, col_wr;
  logic signed [SCORE_W-1:0] col_best;
  logic [RW-1:0]             col_best_row;
  logic                      col_hit;
  logic [1:0]                cur_dir, nxt_dir;
  logic                      dec_row, dec_col, exits, walk_last, accept;
  logic [RW-1:0]             nxt_row;
  logic [CW-1:0]             nxt_col;

  // Columns are accepted in IDLE and CAPTURE; clear_en suppresses everything.
  assign capturing = ((state_q == S_IDLE) || (state_q == S_CAPTURE)) && !clear_en_i;
  assign col_full  = (col_cnt_q == NW'(MAX_COLS));
  assign col_wr    = capturing && col_valid_i && !col_full;
  assign accept    = op_if.op_valid && op_if.op_ready;

  // Best cell of the incoming column against the running max; rows scanned
  // ascending with strict compare so ties keep the earlier column / lower row.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    col_best     = max_score_q;
    col_best_row = '0;
    col_hit      = 1'b0;
    for (int r = 0; r < N_PE; r++) begin
      if ($signed(col_score_i[r*SCORE_W +: SCORE_W]) > col_best) begin
        col_best     = $signed(col_score_i[r*SCORE_W +: SCORE_W]);
        col_best_row = RW'(r);
        col_hit      = 1'b1;
      end
    end
  end

  // Walk step: decode the cursor cell, form the next cursor and decide op_last.
  always_comb begin
    cur_dir   = dir_q[cur_col_q][cur_row_q];
    dec_row   = (cur_dir == DIR_DIAG) || (cur_dir == DIR_UP);
    dec_col   = (cur_dir == DIR_DIAG) || (cur_dir == DIR_LEFT);
    nxt_row   = dec_row ? cur_row_q - RW'(1) : cur_row_q;
    nxt_col   = dec_col ? cur_col_q - CW'(1) : cur_col_q;
    exits     = (dec_row && (cur_row_q == '0)) || (dec_col && (cur_col_q == '0));
    nxt_dir   = dir_q[nxt_col][nxt_row];
    walk_last = exits || (nxt_dir == DIR_ZERO);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; window_end in IDLE behaves as in CAPTURE (empty or
  // single-column window) and clear_en overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (window_end_i) state_d = S_SEEK;
                 else if (col_valid_i) state_d = S_CAPTURE;
      S_CAPTURE: if (window_end_i) state_d = S_SEEK;
      S_SEEK:    state_d = (max_score_q == '0) ? S_DONE : S_WALK;
      S_WALK:    if (cur_dir == DIR_ZERO) state_d = S_DONE;
                 else if (accept && walk_last) state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (clear_en_i) state_d = S_IDLE;
  end

  // Output decode; a ZERO cursor cell at WALK entry emits nothing.
  always_comb begin
    op_if.op_valid = 1'b0;
    op_if.op_code  = 2'd0;
    op_if.op_last  = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    unique case (state_q)
      S_SEEK: busy_o = 1'b1;
      S_WALK: begin
        busy_o = 1'b1;
        if (cur_dir != DIR_ZERO) begin
          op_if.op_valid = 1'b1;
          op_if.op_code  = cur_dir;
          op_if.op_last  = walk_last;
        end
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Window bookkeeping: column count, best cell, overflow, cursor, start cell.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_en_i) begin
      col_cnt_q   <= '0;
      max_score_q <= '0;
      end_row_q   <= '0;
      end_col_q   <= '0;
      start_row_q <= '0;
      start_col_q <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (capturing && col_valid_i) begin
        if (col_full) begin
          overflow_q <= 1'b1;
        end else begin
          col_cnt_q <= col_cnt_q + NW'(1);
          if (col_hit) begin
            max_score_q <= col_best;
            end_row_q   <= col_best_row;
            end_col_q   <= col_cnt_q[CW-1:0];
          end
        end
      end
      if (state_q == S_SEEK) begin
        cur_row_q <= end_row_q;
        cur_col_q <= end_col_q;
      end
      if (accept) begin
        start_row_q <= cur_row_q;
        start_col_q <= cur_col_q;
        cur_row_q   <= nxt_row;
        cur_col_q   <= nxt_col;
      end
    end
  end

  // Direction matrix storage, one column written per accepted col_valid.
  always_ff @(posedge clk) begin
    // NOTE: the matrix is never read beyond the columns of the current window, so it carries no reset.
    if (col_wr) begin
      for (int r = 0; r < N_PE; r++) begin
        dir_q[col_cnt_q[CW-1:0]][r] <= col_dir_i[2*r +: 2];
      end
    end
  end

  assign max_score_o = max_score_q;
  assign end_row_o   = end_row_q;
  assign end_col_o   = end_col_q;
  assign start_row_o = start_row_q;
  assign start_col_o = start_col_q;
  assign overflow_o  = overflow_q;

endmodule
